// File: rtl/exp_pkg.sv
// ---------------------------------------------------------------------------
// exp_pkg
// Shared definitions for the bit-serial base-2 exponential unit:
//   state_e   - control FSM states
//   EXP_TBL_W - fraction width of the constant table
//   EXP_C     - 2^(2^-i) for i = 1..16, unsigned 1.24, rounded to nearest
// ---------------------------------------------------------------------------
package exp_pkg;

    typedef enum logic [1:0] {
        WAIT0,  // waiting for start to be seen low
        WAIT1,  // armed; a high start launches an operation
        RUN,    // consuming one exponent bit per cycle
        ROUND   // rounding / saturating the accumulator into x
    } state_e;

    localparam int EXP_TBL_W = 24;
    localparam int EXP_TBL_N = 16;

    // 2^(2^-i): integer bit followed by 24 fraction bits.
    localparam logic [EXP_TBL_W:0] EXP_C [1:EXP_TBL_N] = '{
        25'h16A09E6,  // i=1  : 1.414213562
        25'h1306FE1,  // i=2  : 1.189207115
        25'h1172B84,  // i=3  : 1.090507733
        25'h10B5587,  // i=4  : 1.044273782
        25'h1059B0D,  // i=5  : 1.021897149
        25'h102C9A4,  // i=6  : 1.010889286
        25'h10163DB,  // i=7  : 1.005429901
        25'h100B1B0,  // i=8  : 1.002711275
        25'h10058C8,  // i=9  : 1.001354720
        25'h1002C60,  // i=10 : 1.000677131
        25'h100162F,  // i=11 : 1.000338508
        25'h1000B17,  // i=12 : 1.000169240
        25'h100058C,  // i=13 : 1.000084616
        25'h10002C6,  // i=14 : 1.000042307
        25'h1000163,  // i=15 : 1.000021153
        25'h10000B1   // i=16 : 1.000010577
    };

endpackage

// File: rtl/exp_const_rom.sv
// ---------------------------------------------------------------------------
// exp_const_rom
// Combinational lookup of the recurrence constant C[i] = 2^(2^-i),
// truncated from the 1.24 table to the accumulator's 1.m format.
// Ports:
//   idx - iteration index i (1..16 are valid)
//   c   - C[idx] in unsigned 1.m; 1.0 for indices outside the table
// ---------------------------------------------------------------------------
module exp_const_rom #(
    parameter int m = 16,
    parameter int k = 5
) (
    input  logic [k-1:0] idx,
    output logic [m:0]   c
);
    import exp_pkg::*;

    logic [4:0] tbl_idx;

    // NOTE: every output of a combinational block gets a default first so
    // no path through the block leaves a value held, which would infer a latch.
    always_comb begin
        tbl_idx = '0;
        c       = {1'b1, {m{1'b0}}};  // 1.0 is the neutral multiplier
        if (int'(idx) >= 1 && int'(idx) <= EXP_TBL_N) begin
            tbl_idx = 5'(idx);
            c       = EXP_C[tbl_idx][EXP_TBL_W -: m+1];
        end
    end

endmodule

// File: rtl/exponential.sv
// ---------------------------------------------------------------------------
// exponential
// Bit-serial antilogarithm: x = 2^f for a fraction f in [0,1), x in [1,2).
// One exponent bit is consumed per clock; when bit i is set the accumulator
// is multiplied by 2^(2^-i). The result is rounded to n fraction bits.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-low reset
//   start - level request; a 0 seen while idle followed by a 1 launches
//   y     - exponent fraction, y[1] has weight 2^-1; sampled at launch only
//   x     - result, unsigned 1.n (x[0] is the integer bit); held until the
//           next completion
//   done  - high when idle with a valid result, low while busy
// ---------------------------------------------------------------------------
module exponential #(
    parameter int n = 8,   // output fraction bits
    parameter int m = 16,  // accumulator fraction bits, n+2 <= m <= 24
    parameter int k = 5,   // iteration counter width, 2^k > p
    parameter int p = 16   // input fraction bits, 1 <= p <= 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:p] y,
    output logic [0:n] x,
    output logic       done
);
    import exp_pkg::*;

    localparam logic [m:0]   ACC_ONE  = {1'b1, {m{1'b0}}};
    localparam logic [k-1:0] CNT_LAST = k'(p);
    // Half an output LSB, aligned to the accumulator's fraction.
    localparam logic [m+1:0] RND_HALF = (m+2)'(2 ** (m - n - 1));

    state_e       state_q, state_d;
    logic [m:0]   acc_q,   acc_d;
    logic [k-1:0] count_q, count_d;
    logic [1:p]   yreg_q,  yreg_d;
    logic [0:n]   x_q,     x_d;
    logic         done_q,  done_d;

    logic [m:0]     c_tbl;
    logic [2*m+1:0] prod;
    logic [m:0]     acc_mul;
    logic [m+1:0]   rnd_sum;

    exp_const_rom #(
        .m (m),
        .k (k)
    ) u_rom (
        .idx (count_q),
        .c   (c_tbl)
    );

    // 1.m x 1.m gives 2.2m; both factors are below 2 and their product stays
    // below 2, so bits [2m:m] hold the truncated 1.m result.
    assign prod    = {{(m+1){1'b0}}, acc_q} * {{(m+1){1'b0}}, c_tbl};
    assign acc_mul = (m+1)'(prod >> m);

    // Round to nearest at fraction bit n; a carry into bit m+1 means 2.0.
    assign rnd_sum = {1'b0, acc_q} + RND_HALF;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        yreg_d  = yreg_q;
        x_d     = x_q;
        done_d  = done_q;

        unique case (state_q)
            // Requiring a low start first stops a held-high start from
            // relaunching after completion or after reset.
            WAIT0: begin
                if (!start) state_d = WAIT1;
            end
            WAIT1: begin
                if (start) begin
                    yreg_d  = y;
                    acc_d   = ACC_ONE;
                    count_d = k'(1);
                    done_d  = 1'b0;
                    state_d = RUN;
                end
            end
            // yreg shifts left so its leading bit is always y[count].
            RUN: begin
                if (yreg_q[1]) acc_d = acc_mul;
                yreg_d  = yreg_q << 1;
                count_d = count_q + k'(1);
                if (count_q == CNT_LAST) state_d = ROUND;
            end
            ROUND: begin
                x_d     = rnd_sum[m+1] ? '1 : (n+1)'(rnd_sum >> (m - n));
                done_d  = 1'b1;
                state_d = WAIT0;
            end
            default: state_d = WAIT0;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= WAIT0;
            acc_q   <= '0;
            count_q <= '0;
            yreg_q  <= '0;
            x_q     <= '0;
            done_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            yreg_q  <= yreg_d;
            x_q     <= x_d;
            done_q  <= done_d;
        end
    end

    assign x    = x_q;
    assign done = done_q;

endmodule

// File: tb/tb_exponential.sv
// ---------------------------------------------------------------------------
// tb_exponential
// Directed bench for the exponential unit. Expected results are queued when
// an operation is launched and compared when done returns high.
// ---------------------------------------------------------------------------
module tb_exponential;

    localparam int N = 8;
    localparam int M = 16;
    localparam int K = 5;
    localparam int P = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:P] y;
    logic [0:N] x;
    logic       done;

    exponential #(
        .n (N),
        .m (M),
        .k (K),
        .p (P)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .y     (y),
        .x     (x),
        .done  (done)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    logic [0:N] exp_q[$];
    logic [0:N] last_x = '0;  // result the DUT should be holding

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Launch one operation from idle. y_late is driven onto y right after
    // the launch edge; the result must still reflect yv.
    task automatic run_op(input string tag, input logic [1:P] yv,
                          input logic [1:P] y_late, input logic [0:N] expv);
        int         busy;
        logic [0:N] want;
        @(negedge clk);
        start = 1'b0;
        y     = yv;
        @(negedge clk);
        start = 1'b1;
        exp_q.push_back(expv);
        @(negedge clk);  // launch edge has passed
        y = y_late;
        check({tag, ":launch_done_low"}, 32'(done), 32'd0);
        busy = 0;
        while (done !== 1'b1 && busy < 200) begin
            busy++;
            if (busy == 8) check({tag, ":x_held"}, 32'(x), 32'(last_x));
            @(negedge clk);
        end
        check({tag, ":busy_cycles"}, 32'(busy), 32'(P + 1));
        want = exp_q.pop_front();
        check({tag, ":result"}, 32'(x), 32'(want));
        last_x = want;
    endtask

    initial begin
        // Reset with start held high: no operation may start on release.
        reset = 1'b0;
        start = 1'b1;
        y     = '0;
        repeat (3) @(negedge clk);
        check("rst:done", 32'(done), 32'd1);
        check("rst:x", 32'(x), 32'd0);
        reset = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("rst:no_launch", 32'(done), 32'd1);
        end
        check("rst:x_after", 32'(x), 32'd0);

        run_op("y0000", 16'h0000, 16'h0000, 9'h100);
        run_op("y8000", 16'h8000, 16'h8000, 9'h16A);
        run_op("y4000", 16'h4000, 16'h4000, 9'h130);
        run_op("y2000", 16'h2000, 16'h2000, 9'h117);
        run_op("yC000", 16'hC000, 16'hC000, 9'h1AF);
        // y changes after launch; the latched value must be used.
        run_op("ylate", 16'h8000, 16'hFFFF, 9'h16A);
        // Rounding reaches 2.0 and saturates.
        run_op("yFFFF", 16'hFFFF, 16'hFFFF, 9'h1FF);

        // start stays high after completion: no second operation.
        repeat (6) begin
            @(negedge clk);
            check("hold:no_retrigger", 32'(done), 32'd1);
        end
        check("hold:x", 32'(x), 32'h1FF);

        // Abort mid-operation with reset.
        @(negedge clk);
        start = 1'b0;
        y     = 16'h8000;
        @(negedge clk);
        start = 1'b1;
        repeat (8) @(negedge clk);
        check("abort:busy", 32'(done), 32'd0);
        reset = 1'b0;
        #1;
        check("abort:done", 32'(done), 32'd1);
        check("abort:x", 32'(x), 32'd0);
        last_x = '0;
        @(negedge clk);
        reset = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("abort:no_launch", 32'(done), 32'd1);
        end

        // A fresh 0->1 on start works again after the abort.
        run_op("post_abort", 16'h4000, 16'h0000, 9'h130);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
